// File: rtl/multicycle_core.sv
// Single-memory multicycle core for a small MIPS-like subset.
// Control FSM, IR/MDR/A/B/ALUOut, 32x32 register file and ALU.
module multicycle_core #(
    parameter logic [31:0] PC_START    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  err_code
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [31:0] wait_q, wait_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rf_q [32];

    logic        rf_we, req, retire_c, tmo, zero, funct_ok;
    logic [4:0]  rf_waddr, rs, rt, rd;
    logic [5:0]  op, funct;
    logic [31:0] rf_wdata, simm, rs_val, rt_val, alu_r;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign zero   = (a_q - b_q) == 32'd0;
    // Next non-ready cycle would reach the limit: give up instead.
    assign tmo    = (MEM_TIMEOUT != 0) && (wait_q + 32'd1 == MEM_TIMEOUT);

    always_comb begin
        funct_ok = 1'b1;
        alu_r    = a_q + b_q;
        case (funct)
            F_ADD:   alu_r = a_q + b_q;
            F_SUB:   alu_r = a_q - b_q;
            F_AND:   alu_r = a_q & b_q;
            F_OR:    alu_r = a_q | b_q;
            F_SLT:   alu_r = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        wait_d   = 32'd0;
        err_d    = err_q;
        req      = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        retire_c = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        unique case (state_q)
            FETCH: begin
                req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DECODE;
                end else if (tmo) begin
                    state_d = HALT;
                    err_d   = 2'b10;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + (simm << 2);
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_R: begin
                        state_d = funct_ok ? EXEC : HALT;
                        err_d   = funct_ok ? err_q : 2'b01;
                    end
                    default: begin
                        state_d = HALT;
                        err_d   = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                alu_d   = a_q + simm;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                req      = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = MEMWB;
                end else if (tmo) begin
                    state_d = HALT;
                    err_d   = 2'b10;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = mdr_q;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                req      = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end else if (tmo) begin
                    state_d = HALT;
                    err_d   = 2'b10;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            EXEC: begin
                alu_d   = alu_r;
                state_d = ALUWB;
            end
            ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            ADDIEX: begin
                alu_d   = a_q + simm;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                rf_we    = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                if (zero) pc_d = alu_q;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= PC_START;
            ir_q    <= 32'd0;
            mdr_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            alu_q   <= 32'd0;
            wait_q  <= 32'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Register file keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end

    assign mem_req   = req & reset;
    assign retire    = retire_c & reset;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    assign err_code  = err_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: ISA-level reference model
// predicts memory transactions and per-instruction cycle counts.
module tb_multicycle_core;

    localparam logic [31:0] PCS = 32'h0000_0000;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [1:0]  err_code;

    multicycle_core #(.PC_START(PCS), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .retire(retire), .halted(halted),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] prog[$];
    int passed = 0, total = 0;
    bit sb_on = 0, stall_all = 0, in_txn = 0;
    int waits_left = 0, fmin = 0, fmax = 0, dmin = 0, dmax = 0;
    int cyc = 0, wcnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                          input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt,
                                          input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] jtype(input int w);
        return {6'b000010, 26'(w)};
    endfunction

    task automatic put(input int idx, input logic [31:0] w);
        while (prog.size() <= idx) prog.push_back(32'd0);
        prog[idx] = w;
    endtask

    // Memory responder: random wait states, fetch and data separately.
    always @(negedge clk) begin
        if (!reset || !mem_req || stall_all) begin
            mem_ready = 1'b0;
            in_txn    = 1'b0;
        end else begin
            if (!in_txn) begin
                in_txn = 1'b1;
                if (mem_addr == pc)
                    waits_left = int'($urandom_range(fmax, fmin));
                else
                    waits_left = int'($urandom_range(dmax, dmin));
            end
            if (waits_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                in_txn = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                waits_left--;
            end
        end
    end

    // Monitor: pops the scoreboard on each completed transaction/retire.
    always begin
        txn_t e;
        @(negedge clk);
        #1;
        if (reset && sb_on) begin
            cyc++;
            if (mem_req && !mem_ready) wcnt++;
            if (mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL txn_extra: got addr %h, expected none",
                             mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_addr", mem_addr, e.addr);
                    chk("txn_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("txn_wdata", mem_wdata, e.wdata);
                end
            end
            if (retire) begin
                if (exp_cyc_q.size() == 0) begin
                    total++;
                    $display("FAIL retire_extra: got retire, expected none");
                end else begin
                    chk("cycles", 32'(cyc), 32'(exp_cyc_q.pop_front() + wcnt));
                end
                cyc  = 0;
                wcnt = 0;
            end
        end
    end

    // Instruction-level reference: executes the program from ref_mem.
    task automatic model(output logic [31:0] fpc);
        logic [31:0] r [32];
        logic [31:0] p, ins, npc, a, b, simm, ea, res;
        bit done;
        txn_t t;
        done = 0;
        p = PCS;
        res = 32'd0;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        for (int s = 0; s < 1000 && !done; s++) begin
            t = {p, 1'b0, 32'd0};
            exp_q.push_back(t);
            ins  = ref_mem[p[9:2]];
            npc  = p + 32'd4;
            a    = r[ins[25:21]];
            b    = r[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = a + simm;
            case (ins[31:26])
                6'h00: begin
                    case (ins[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: done = 1;
                    endcase
                    if (!done) begin
                        r[ins[15:11]] = res;
                        exp_cyc_q.push_back(4);
                    end
                end
                6'h23: begin
                    t = {ea, 1'b0, 32'd0};
                    exp_q.push_back(t);
                    r[ins[20:16]] = ref_mem[ea[9:2]];
                    exp_cyc_q.push_back(5);
                end
                6'h2b: begin
                    t = {ea, 1'b1, b};
                    exp_q.push_back(t);
                    ref_mem[ea[9:2]] = b;
                    exp_cyc_q.push_back(4);
                end
                6'h04: begin
                    if (a == b) npc = npc + (simm << 2);
                    exp_cyc_q.push_back(3);
                end
                6'h08: begin
                    r[ins[20:16]] = ea;
                    exp_cyc_q.push_back(4);
                end
                6'h02: begin
                    npc = {npc[31:28], ins[25:0], 2'b00};
                    exp_cyc_q.push_back(3);
                end
                default: done = 1;
            endcase
            r[0] = 32'd0;
            p = npc;
        end
        fpc = p;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = (i >= 128 && i < 192) ? $urandom() : 32'd0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    endtask

    task automatic run_prog(input int f0, input int f1, input int d0,
                            input int d1, input string tag);
        logic [31:0] fpc;
        bit seen;
        reset = 1'b0;
        sb_on = 0;
        stall_all = 0;
        @(negedge clk);
        #2;
        load_mem();
        chk({tag, "_rst_pc"}, pc, PCS);
        chk({tag, "_rst_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_rst_ret"}, 32'(retire), 32'd0);
        chk({tag, "_rst_halt"}, 32'(halted), 32'd0);
        chk({tag, "_rst_err"}, 32'(err_code), 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        model(fpc);
        fmin = f0; fmax = f1; dmin = d0; dmax = d1;
        cyc = 0; wcnt = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb_on = 1;
        for (int c = 0; c < 4000 && !halted; c++) @(negedge clk);
        #2;
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_err"}, 32'(err_code), 32'd1);
        chk({tag, "_pc"}, pc, fpc);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #2;
            if (mem_req || retire) seen = 1;
        end
        chk({tag, "_quiet"}, 32'(seen), 32'd0);
        chk({tag, "_txn_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_ret_left"}, 32'(exp_cyc_q.size()), 32'd0);
        sb_on = 0;
    endtask

    task automatic gen_random();
        logic [5:0] fns [5];
        int k, rs, rt, rd;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
        fns[3] = 6'h25; fns[4] = 6'h2a;
        prog.delete();
        for (int r = 1; r <= 7; r++)
            put(r - 1, itype(6'h08, 0, r, 16'($urandom())));
        for (int i = 7; i <= 26; i++) begin
            k  = int'($urandom_range(9, 0));
            rs = int'($urandom_range(7, 0));
            rt = int'($urandom_range(7, 0));
            rd = int'($urandom_range(7, 0));
            if (k < 5) put(i, rtype(rs, rt, rd, fns[k]));
            else if (k == 5) put(i, itype(6'h08, rs, rt, 16'($urandom())));
            else if (k == 6)
                put(i, itype(6'h2b, 0, rt, 16'(32'h200 + 4 * $urandom_range(15, 0))));
            else if (k == 7)
                put(i, itype(6'h23, 0, rt, 16'(32'h200 + 4 * $urandom_range(15, 0))));
            else if (k == 8)
                put(i, itype(6'h04, rs, ($urandom_range(1, 0) != 0) ? rs : rt,
                             16'($urandom_range(3, 0))));
            else put(i, jtype(int'($urandom_range(34, i + 1))));
        end
        for (int r = 1; r <= 7; r++)
            put(26 + r, itype(6'h2b, 0, r, 16'(32'h300 + 4 * (r - 1))));
        put(34, ILL);
    endtask

    initial begin
        logic [31:0] p0;
        bit found;
        // Straight-line arithmetic, zero wait.
        prog.delete();
        put(0, itype(6'h08, 0, 1, 16'd5));
        put(1, itype(6'h08, 0, 2, 16'hFFFD));
        put(2, rtype(1, 2, 3, 6'h20));
        put(3, rtype(2, 1, 4, 6'h2a));
        put(4, itype(6'h2b, 0, 3, 16'h300));
        put(5, itype(6'h2b, 0, 4, 16'h304));
        put(6, ILL);
        run_prog(0, 0, 0, 0, "arith");
        chk("arith_r3", mem[192], 32'd2);
        chk("arith_r4", mem[193], 32'd1);

        // Store then load with two wait cycles on each data access.
        prog.delete();
        put(0, itype(6'h08, 0, 3, 16'd2));
        put(1, jtype(16));
        put(16, itype(6'h2b, 0, 3, 16'd8));
        put(17, itype(6'h23, 0, 5, 16'd8));
        put(18, itype(6'h2b, 0, 5, 16'h300));
        put(19, ILL);
        run_prog(0, 0, 2, 2, "ldst");
        chk("ldst_m8", mem[2], 32'd2);
        chk("ldst_r5", mem[192], 32'd2);

        // Taken branch at 0x10, not-taken branch, jump to 0x100.
        prog.delete();
        put(0, itype(6'h08, 0, 1, 16'd1));
        put(1, itype(6'h08, 0, 2, 16'd2));
        put(2, itype(6'h08, 0, 3, 16'd7));
        put(3, itype(6'h08, 0, 4, 16'd9));
        put(4, itype(6'h04, 1, 1, 16'd2));
        put(5, ILL);
        put(6, ILL);
        put(7, itype(6'h04, 1, 2, 16'd3));
        put(8, jtype(32'h40));
        put(64, itype(6'h2b, 0, 1, 16'h300));
        put(65, ILL);
        run_prog(0, 1, 0, 1, "branch");
        chk("branch_pc", pc, 32'h108);

        // Not-taken branch at 0x10 into an illegal R-type funct.
        prog.delete();
        put(0, itype(6'h08, 0, 1, 16'd1));
        put(1, itype(6'h08, 0, 2, 16'd2));
        put(2, itype(6'h08, 0, 3, 16'd3));
        put(3, itype(6'h08, 0, 4, 16'd4));
        put(4, itype(6'h04, 1, 2, 16'd2));
        put(5, 32'h0000_0000);
        run_prog(0, 0, 0, 0, "ntaken");
        chk("ntaken_pc", pc, 32'h18);

        // Fetch never completes: timeout after four wait cycles.
        reset = 1'b0;
        stall_all = 1;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("tmo_early", 32'(halted), 32'd0);
        @(posedge clk);
        #2;
        chk("tmo_halt", 32'(halted), 32'd1);
        chk("tmo_err", 32'(err_code), 32'd2);
        chk("tmo_pc", pc, PCS);
        chk("tmo_req", 32'(mem_req), 32'd0);

        // Reset asserted while a load is waiting on memory.
        reset = 1'b0;
        stall_all = 0;
        prog.delete();
        put(0, itype(6'h23, 0, 5, 16'h200));
        put(1, ILL);
        @(negedge clk);
        load_mem();
        fmin = 0; fmax = 0; dmin = 3; dmax = 3;
        @(posedge clk);
        #2;
        reset = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            #2;
            if (mem_req && mem_addr == 32'h200) found = 1;
        end
        chk("abort_seen", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_pc", pc, PCS);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("fresh_req", 32'(mem_req), 32'd1);
        chk("fresh_addr", mem_addr, PCS);
        chk("fresh_we", 32'(mem_we), 32'd0);

        // Randomized programs with random wait states.
        for (int n = 0; n < 8; n++) begin
            gen_random();
            if (n == 0) run_prog(0, 0, 0, 0, "rand");
            else run_prog(0, 2, 0, 2, "rand");
        end

        p0 = 32'(passed);
        $display("%0d/%0d checks passed", p0, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
